// File: rtl/l1_align_accum.sv
// L1 mantissa aligner and packet accumulator: per-lane alignment (FP4 or quad weights),
// a pipelined lane-sum tree and a saturating sign-magnitude packet accumulator.
module l1_align_accum #(
  parameter int NUM_LANES = 4,
  parameter int MANT_W    = 4,
  parameter int EXP_W     = 6,
  parameter int MAX_SHIFT = 4,
  parameter int ACC_W     = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [1:0]                  prec_mode_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic                        in_last_i,
  input  logic [NUM_LANES*MANT_W-1:0] in_mant_i,
  input  logic [NUM_LANES*EXP_W-1:0]  in_exp_i,
  input  logic [NUM_LANES-1:0]        in_sign_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [ACC_W-1:0]            out_mant_o,
  output logic [EXP_W-1:0]            out_exp_o,
  output logic                        out_sign_o,
  output logic                        out_ovf_o
);

  localparam int QUAD_SH = 4;
  localparam int TERM_W  = MANT_W + ((MAX_SHIFT > QUAD_SH) ? MAX_SHIFT : QUAD_SH) + 1;
  localparam int SUM_W   = TERM_W + 1 + $clog2(NUM_LANES);
  localparam int ACC_SW  = ACC_W + 1;
  localparam int WIDE_W  = ((ACC_SW > SUM_W) ? ACC_SW : SUM_W) + 1;
  localparam logic signed [WIDE_W-1:0] SAT_HI = WIDE_W'((64'd1 << ACC_W) - 64'd1);
  localparam logic signed [WIDE_W-1:0] SAT_LO = -SAT_HI;

  function automatic int fp4_shift(input logic [2:0] e);
    int sh;
    sh = int'(e) - 2;
    if (sh < 0) sh = 0;
    else if (sh > MAX_SHIFT) sh = MAX_SHIFT;
    return sh;
  endfunction

  function automatic int quad_shift(input int pos);
    if (pos == 0) return 0;
    else if (pos == 3) return QUAD_SH;
    else return 2;
  endfunction

  function automatic logic signed [TERM_W-1:0] lane_term(input logic [MANT_W-1:0] m,
                                                         input int sh, input logic neg);
    logic [TERM_W-1:0] mag;
    mag = TERM_W'(m) << sh;
    return neg ? -$signed(mag) : $signed(mag);
  endfunction

  function automatic logic signed [ACC_SW-1:0] sat_acc(input logic signed [WIDE_W-1:0] v);
    if (v > SAT_HI) return ACC_SW'(SAT_HI);
    else if (v < SAT_LO) return ACC_SW'(SAT_LO);
    else return ACC_SW'(v);
  endfunction

  function automatic logic [ACC_W-1:0] magnitude(input logic signed [ACC_SW-1:0] v);
    return v[ACC_SW-1] ? ACC_W'(-v) : ACC_W'(v);
  endfunction

  logic                     w_advance;
  logic                     w_mode_fp4_p0;
  logic [EXP_W-1:0]         w_exp_p0;
  logic signed [TERM_W-1:0] w_term_p0 [NUM_LANES];
  logic                     w_unused_exp;

  logic                     r_first;
  logic                     r_mode_fp4;
  logic [EXP_W-1:0]         r_pkt_exp;

  logic                     r_vld_p1;
  logic                     r_last_p1;
  logic [EXP_W-1:0]         r_exp_p1;
  logic signed [TERM_W-1:0] r_term_p1 [NUM_LANES];
  logic signed [SUM_W-1:0]  w_sum_p1;

  logic                     r_vld_p2;
  logic                     r_last_p2;
  logic [EXP_W-1:0]         r_exp_p2;
  logic signed [SUM_W-1:0]  r_sum_p2;
  logic signed [WIDE_W-1:0] w_raw_p2;
  logic                     w_sat_p2;
  logic signed [ACC_SW-1:0] w_nxt_p2;

  logic signed [ACC_SW-1:0] r_acc;
  logic                     r_ovf;
  logic                     r_out_valid;
  logic [ACC_W-1:0]         r_out_mant;
  logic [EXP_W-1:0]         r_out_exp;
  logic                     r_out_sign;
  logic                     r_out_ovf;

  assign w_advance  = !r_out_valid || out_ready_i;
  assign in_ready_o = w_advance;
  // Only lane 0 exponent (quad) and the low 3 bits per lane (FP4) carry information.
  assign w_unused_exp = ^in_exp_i;

  // ---- Stage p0: mode/exponent selection and per-lane alignment ----
  assign w_mode_fp4_p0 = r_first ? (prec_mode_i == 2'b11) : r_mode_fp4;
  assign w_exp_p0 = !r_first ? r_pkt_exp : (w_mode_fp4_p0 ? '0 : in_exp_i[EXP_W-1:0]);

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (w_mode_fp4_p0)
        w_term_p0[i] = lane_term(in_mant_i[i*MANT_W +: MANT_W],
                                 fp4_shift(in_exp_i[i*EXP_W +: 3]), in_sign_i[i]);
      else
        w_term_p0[i] = lane_term(in_mant_i[i*MANT_W +: MANT_W],
                                 quad_shift(i % 4), in_sign_i[i - (i % 4)]);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_first    <= 1'b1;
      r_mode_fp4 <= 1'b0;
      r_vld_p1   <= 1'b0;
      r_vld_p2   <= 1'b0;
    end else if (w_advance) begin
      r_vld_p1 <= in_valid_i;
      r_vld_p2 <= r_vld_p1;
      if (in_valid_i) begin
        r_first <= in_last_i;
        if (r_first) r_mode_fp4 <= w_mode_fp4_p0;
      end
    end
  end

  // ---- Stage p1/p2: aligned terms, then the reduced beat sum ----
  always_ff @(posedge clk_i) begin
    if (w_advance) begin
      if (in_valid_i && r_first) r_pkt_exp <= w_exp_p0;
      r_term_p1 <= w_term_p0;
      r_last_p1 <= in_last_i;
      r_exp_p1  <= w_exp_p0;
      r_sum_p2  <= w_sum_p1;
      r_last_p2 <= r_last_p1;
      r_exp_p2  <= r_exp_p1;
    end
  end

  always_comb begin
    w_sum_p1 = '0;
    for (int i = 0; i < NUM_LANES; i++)
      w_sum_p1 = w_sum_p1 + SUM_W'(r_term_p1[i]);
  end

  // ---- Stage p3: saturating accumulate and result register ----
  assign w_raw_p2 = WIDE_W'(r_acc) + WIDE_W'(r_sum_p2);
  assign w_sat_p2 = (w_raw_p2 > SAT_HI) || (w_raw_p2 < SAT_LO);
  assign w_nxt_p2 = sat_acc(w_raw_p2);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_mant  <= '0;
      r_out_exp   <= '0;
      r_out_sign  <= 1'b0;
      r_out_ovf   <= 1'b0;
    end else if (w_advance) begin
      r_out_valid <= r_vld_p2 && r_last_p2;
      if (r_vld_p2) begin
        if (r_last_p2) begin
          r_out_mant <= magnitude(w_nxt_p2);
          r_out_sign <= w_nxt_p2[ACC_SW-1];
          r_out_exp  <= r_exp_p2;
          r_out_ovf  <= r_ovf || w_sat_p2;
          r_acc      <= '0;
          r_ovf      <= 1'b0;
        end else begin
          r_acc <= w_nxt_p2;
          r_ovf <= r_ovf || w_sat_p2;
        end
      end
    end
  end

  assign out_valid_o = r_out_valid;
  assign out_mant_o  = r_out_mant;
  assign out_exp_o   = r_out_exp;
  assign out_sign_o  = r_out_sign;
  assign out_ovf_o   = r_out_ovf;

endmodule

// File: tb/tb_l1_align_accum.sv
// Bench for l1_align_accum: vector table plus scoreboard, with hand sequences for
// latency, saturation, backpressure and mid-packet reset.
module tb_l1_align_accum;
  localparam int NL = 4;
  localparam int MW = 4;
  localparam int EW = 6;
  localparam int MS = 4;
  localparam int AW = 12;
  localparam int NV = 13;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       prec_mode;
  logic             in_valid;
  logic             in_ready;
  logic             in_last;
  logic [NL*MW-1:0] in_mant;
  logic [NL*EW-1:0] in_exp;
  logic [NL-1:0]    in_sign;
  logic             out_valid;
  logic             out_ready;
  logic [AW-1:0]    out_mant;
  logic [EW-1:0]    out_exp;
  logic             out_sign;
  logic             out_ovf;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  mode;
    logic        last;
    logic [15:0] mant;
    logic [23:0] exps;
    logic [3:0]  sgn;
    int          gap;
    logic [11:0] e_mant;
    logic [5:0]  e_exp;
    logic        e_sign;
    logic        e_ovf;
  } vec_t;

  typedef struct {
    logic [11:0] m;
    logic [5:0]  e;
    logic        s;
    logic        o;
  } res_t;

  vec_t vecs [NV];
  res_t sb_q [$];
  res_t mon_r;

  always #5 clk = ~clk;

  l1_align_accum #(.NUM_LANES(NL), .MANT_W(MW), .EXP_W(EW), .MAX_SHIFT(MS), .ACC_W(AW)) dut (
    .clk_i(clk), .rst_i(rst), .prec_mode_i(prec_mode),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_last_i(in_last),
    .in_mant_i(in_mant), .in_exp_i(in_exp), .in_sign_i(in_sign),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_mant_o(out_mant),
    .out_exp_o(out_exp), .out_sign_o(out_sign), .out_ovf_o(out_ovf)
  );

  function automatic logic [15:0] pk_m(input int a, input int b, input int c, input int d);
    return {4'(d), 4'(c), 4'(b), 4'(a)};
  endfunction

  function automatic logic [23:0] pk_e(input int a, input int b, input int c, input int d);
    return {6'(d), 6'(c), 6'(b), 6'(a)};
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic push_exp(input int m, input int e, input int s, input int o);
    res_t r;
    r.m = 12'(m);
    r.e = 6'(e);
    r.s = 1'(s);
    r.o = 1'(o);
    sb_q.push_back(r);
  endtask

  task automatic send_beat(input logic [1:0] mode, input logic last, input logic [15:0] m,
                           input logic [23:0] e, input logic [3:0] s);
    logic ok;
    prec_mode = mode;
    in_last   = last;
    in_mant   = m;
    in_exp    = e;
    in_sign   = s;
    in_valid  = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && sb_q.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", sb_q.size(), 0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=%0d required=none", out_mant);
      end else begin
        mon_r = sb_q.pop_front();
        chk("res_mant", int'(out_mant), int'(mon_r.m));
        chk("res_exp", int'(out_exp), int'(mon_r.e));
        chk("res_sign", int'(out_sign), int'(mon_r.s));
        chk("res_ovf", int'(out_ovf), int'(mon_r.o));
      end
    end
  end

  initial begin
    vecs[0]  = '{2'b11, 1'b1, pk_m(6,4,15,0),    pk_e(3,2,6,2),   4'b0010, 0, 12'd248, 6'd0,  1'b0, 1'b0};
    vecs[1]  = '{2'b00, 1'b1, pk_m(1,2,3,4),     pk_e(5,5,5,5),   4'b0000, 0, 12'd85,  6'd5,  1'b0, 1'b0};
    vecs[2]  = '{2'b11, 1'b0, pk_m(2,8,0,0),     pk_e(2,2,2,2),   4'b0011, 0, 12'd0,   6'd0,  1'b0, 1'b0};
    vecs[3]  = '{2'b11, 1'b0, pk_m(2,8,0,0),     pk_e(2,2,2,2),   4'b0011, 2, 12'd0,   6'd0,  1'b0, 1'b0};
    vecs[4]  = '{2'b11, 1'b1, pk_m(2,8,0,0),     pk_e(2,2,2,2),   4'b0011, 0, 12'd30,  6'd0,  1'b1, 1'b0};
    vecs[5]  = '{2'b01, 1'b1, pk_m(3,1,0,2),     pk_e(9,20,33,1), 4'b0101, 0, 12'd39,  6'd9,  1'b1, 1'b0};
    vecs[6]  = '{2'b10, 1'b0, pk_m(1,0,0,0),     pk_e(3,7,7,7),   4'b0000, 1, 12'd0,   6'd0,  1'b0, 1'b0};
    vecs[7]  = '{2'b11, 1'b1, pk_m(0,1,0,0),     pk_e(7,7,7,7),   4'b0000, 0, 12'd5,   6'd3,  1'b0, 1'b0};
    vecs[8]  = '{2'b11, 1'b1, pk_m(3,5,1,2),     pk_e(0,1,63,4),  4'b0010, 0, 12'd22,  6'd0,  1'b0, 1'b0};
    vecs[9]  = '{2'b11, 1'b1, pk_m(4,4,0,0),     pk_e(2,2,2,2),   4'b0010, 0, 12'd0,   6'd0,  1'b0, 1'b0};
    vecs[10] = '{2'b00, 1'b1, pk_m(15,15,15,15), pk_e(63,0,0,0),  4'b0000, 3, 12'd375, 6'd63, 1'b0, 1'b0};
    vecs[11] = '{2'b11, 1'b0, pk_m(15,0,0,0),    pk_e(6,2,2,2),   4'b0001, 0, 12'd0,   6'd0,  1'b0, 1'b0};
    vecs[12] = '{2'b11, 1'b1, pk_m(15,15,1,0),   pk_e(6,5,2,2),   4'b0000, 0, 12'd121, 6'd0,  1'b0, 1'b0};

    rst = 1'b1;
    prec_mode = 2'b11;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_mant = '0;
    in_exp = '0;
    in_sign = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_mant", int'(out_mant), 0);
    chk("rst_out_exp", int'(out_exp), 0);
    chk("rst_out_sign", int'(out_sign), 0);
    chk("rst_out_ovf", int'(out_ovf), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;

    for (int i = 0; i < NV; i++) begin
      repeat (vecs[i].gap) begin
        @(posedge clk);
        #1;
      end
      if (vecs[i].last)
        sb_q.push_back(res_t'{vecs[i].e_mant, vecs[i].e_exp, vecs[i].e_sign, vecs[i].e_ovf});
      send_beat(vecs[i].mode, vecs[i].last, vecs[i].mant, vecs[i].exps, vecs[i].sgn);
    end
    drain();

    // Latency: result appears on the third cycle after the accepting edge.
    push_exp(248, 0, 0, 0);
    send_beat(2'b11, 1'b1, pk_m(6,4,15,0), pk_e(3,2,6,2), 4'b0010);
    @(negedge clk);
    chk("lat_cycle1", int'(out_valid), 0);
    @(negedge clk);
    chk("lat_cycle2", int'(out_valid), 0);
    @(negedge clk);
    chk("lat_cycle3", int'(out_valid), 1);
    drain();

    // Saturation, then a clean packet proving the sticky flag was cleared.
    push_exp(4095, 0, 0, 1);
    for (int k = 0; k < 9; k++)
      send_beat(2'b11, k == 8, pk_m(15,15,15,15), pk_e(6,6,6,6), 4'b0000);
    push_exp(12, 0, 0, 0);
    send_beat(2'b11, 1'b1, pk_m(12,0,0,0), pk_e(2,2,2,2), 4'b0000);
    drain();

    // Backpressure with a result pending and more beats queued behind it.
    out_ready = 1'b0;
    push_exp(7, 0, 0, 0);
    send_beat(2'b11, 1'b1, pk_m(7,0,0,0), pk_e(2,2,2,2), 4'b0000);
    push_exp(3, 0, 0, 0);
    send_beat(2'b11, 1'b0, pk_m(1,0,0,0), pk_e(2,2,2,2), 4'b0000);
    send_beat(2'b11, 1'b1, pk_m(2,0,0,0), pk_e(2,2,2,2), 4'b0000);
    push_exp(9, 0, 0, 0);
    fork
      send_beat(2'b11, 1'b1, pk_m(9,0,0,0), pk_e(2,2,2,2), 4'b0000);
      begin
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("bp_in_ready", int'(in_ready), 0);
          chk("bp_out_valid", int'(out_valid), 1);
          chk("bp_out_mant", int'(out_mant), 7);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset in the middle of a packet discards the partial sum.
    send_beat(2'b11, 1'b0, pk_m(15,15,15,15), pk_e(6,6,6,6), 4'b0000);
    send_beat(2'b11, 1'b0, pk_m(15,15,15,15), pk_e(6,6,6,6), 4'b0000);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_out_mant", int'(out_mant), 0);
    chk("mid_rst_out_exp", int'(out_exp), 0);
    chk("mid_rst_out_sign", int'(out_sign), 0);
    chk("mid_rst_out_ovf", int'(out_ovf), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_exp(5, 0, 0, 0);
    send_beat(2'b11, 1'b1, pk_m(5,0,0,0), pk_e(2,2,2,2), 4'b0000);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
